// File: rtl/priority_encoder_seq_if.sv
// Valid/ready bundle for the sequential 8-to-3 priority encoder.
// The slave side is the encoder and the master side is the producer/consumer pair.
interface priority_encoder_seq_if;
    logic [7:0] in;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] out;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       err_zero;

    modport master (
        output in, in_valid, out_ready,
        input  in_ready, out, out_valid, out_last, err_zero
    );

    modport slave (
        input  in, in_valid, out_ready,
        output in_ready, out, out_valid, out_last, err_zero
    );
endinterface

// File: rtl/priority_encoder_seq.sv
// Serializes an 8-bit request vector into its set-bit indices, lowest first.
// Define PRIORITY_ENCODER_SEQ_B2B_EN to accept the next vector on the final beat.
module priority_encoder_seq (
    input  logic                          clk,
    input  logic                          rst,
    priority_encoder_seq_if.slave         bus
);
    typedef enum logic {StIdle, StEmit} state_e;

    state_e     r_state;
    state_e     w_state_next;
    logic [7:0] r_pending;
    logic [7:0] w_pending_next;
    logic       r_err_zero;
    logic       w_err_zero_next;
    logic [2:0] w_idx;
    logic       w_last;
    logic       w_in_ready;
    logic       w_accept;
    logic       w_beat;

    always_comb begin
        w_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (r_pending[i]) w_idx = 3'(i);
        end
    end

    // Exactly one bit set: clearing the lowest set bit leaves nothing.
    assign w_last = (r_pending != 8'd0) && ((r_pending & (r_pending - 8'd1)) == 8'd0);

    always_comb begin
        w_in_ready = 1'b0;
        if (!rst) begin
            if (r_state == StIdle) begin
                w_in_ready = 1'b1;
            end else begin
`ifdef PRIORITY_ENCODER_SEQ_B2B_EN
                w_in_ready = w_last && bus.out_ready;
`else
                w_in_ready = 1'b0;
`endif
            end
        end
    end

    assign w_accept = bus.in_valid && w_in_ready;
    assign w_beat   = (r_state == StEmit) && bus.out_ready;

    always_comb begin
        w_state_next    = r_state;
        w_pending_next  = r_pending;
        w_err_zero_next = w_accept && (bus.in == 8'd0);
        unique case (r_state)
            StIdle: begin
                if (w_accept && (bus.in != 8'd0)) begin
                    w_pending_next = bus.in;
                    w_state_next   = StEmit;
                end
            end
            StEmit: begin
                if (w_beat) begin
                    if (w_last) begin
                        w_pending_next = 8'd0;
                        w_state_next   = StIdle;
                        if (w_accept && (bus.in != 8'd0)) begin
                            w_pending_next = bus.in;
                            w_state_next   = StEmit;
                        end
                    end else begin
                        w_pending_next = r_pending & ~(8'd1 << w_idx);
                    end
                end
            end
            default: begin
                w_state_next   = StIdle;
                w_pending_next = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_pending  <= 8'd0;
            r_err_zero <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pending  <= w_pending_next;
            r_err_zero <= w_err_zero_next;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == StEmit);
    assign bus.out       = w_idx;
    assign bus.out_last  = (r_state == StEmit) && w_last;
    assign bus.err_zero  = r_err_zero;
endmodule

// File: tb/tb_priority_encoder_seq.sv
// Bench for priority_encoder_seq: directed scenarios plus random traffic checked
// against a queue-of-indices reference model.
module tb_priority_encoder_seq;
`ifdef PRIORITY_ENCODER_SEQ_B2B_EN
    localparam bit B2b = 1'b1;
`else
    localparam bit B2b = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    priority_encoder_seq_if bus ();

    priority_encoder_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: indices still owed for the current vector, in order.
    int cur[$];
    bit m_err;
    bit e_val;
    bit e_rdy;

    initial begin
        m_err = 1'b0;
        e_val = 1'b0;
        e_rdy = 1'b0;
    end

    always @(negedge clk) begin
        e_val = cur.size() > 0;
        e_rdy = !rst && (cur.size() == 0 || (B2b && cur.size() == 1 && bus.out_ready));
        check("m_valid", 32'(bus.out_valid), 32'(e_val));
        check("m_ready", 32'(bus.in_ready), 32'(e_rdy));
        check("m_err", 32'(bus.err_zero), 32'(m_err));
        if (e_val) begin
            check("m_out", 32'(bus.out), 32'(cur[0]));
            check("m_last", 32'(bus.out_last), 32'(cur.size() == 1));
        end
    end

    always @(posedge clk) begin
        bit acc;
        if (rst) begin
            cur.delete();
            m_err = 1'b0;
        end else begin
            acc = bus.in_valid && e_rdy;
            if (e_val && bus.out_ready) void'(cur.pop_front());
            m_err = acc && (bus.in == 8'd0);
            if (acc) begin
                for (int i = 0; i < 8; i++) begin
                    if (bus.in[i]) cur.push_back(i);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds in_valid until an edge accepts the vector; returns #1 after that edge.
    task automatic send_vec(input logic [7:0] v);
        bit done;
        done = 1'b0;
        bus.in       = v;
        bus.in_valid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            done = bus.in_ready;
            step();
        end
        bus.in_valid = 1'b0;
        if (!done) check("accept_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        n_total       = 0;
        n_bad         = 0;
        rst           = 1'b1;
        bus.in        = 8'd0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        step();
        step();
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out", 32'(bus.out), 32'd0);
        check("rst_last", 32'(bus.out_last), 32'd0);
        check("rst_err", 32'(bus.err_zero), 32'd0);
        rst = 1'b0;

        bus.out_ready = 1'b1;
        send_vec(8'b0000_1000);
        check("t1_out", 32'(bus.out), 32'd3);
        check("t1_valid", 32'(bus.out_valid), 32'd1);
        check("t1_last", 32'(bus.out_last), 32'd1);
        step();
        check("t1_idle_valid", 32'(bus.out_valid), 32'd0);
        check("t1_idle_ready", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            send_vec(8'd1 << i);
            check("onehot_out", 32'(bus.out), 32'(i));
            check("onehot_last", 32'(bus.out_last), 32'd1);
            step();
        end

        send_vec(8'b1010_0101);
        check("a5_out0", 32'(bus.out), 32'd0);
        check("a5_rdy0", 32'(bus.in_ready), 32'd0);
        step();
        check("a5_out2", 32'(bus.out), 32'd2);
        step();
        check("a5_out5", 32'(bus.out), 32'd5);
        check("a5_last5", 32'(bus.out_last), 32'd0);
        step();
        check("a5_out7", 32'(bus.out), 32'd7);
        check("a5_last7", 32'(bus.out_last), 32'd1);
        step();
        check("a5_done", 32'(bus.out_valid), 32'd0);

        send_vec(8'b1010_0101);
        step();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("stall_out", 32'(bus.out), 32'd2);
            check("stall_valid", 32'(bus.out_valid), 32'd1);
            step();
        end
        bus.out_ready = 1'b1;
        step();
        check("stall_out5", 32'(bus.out), 32'd5);
        step();
        check("stall_out7", 32'(bus.out), 32'd7);
        step();

        send_vec(8'h00);
        check("zero_err", 32'(bus.err_zero), 32'd1);
        check("zero_valid", 32'(bus.out_valid), 32'd0);
        check("zero_ready", 32'(bus.in_ready), 32'd1);
        step();
        check("zero_err_off", 32'(bus.err_zero), 32'd0);

        send_vec(8'hFF);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        check("midrst_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        send_vec(8'h40);
        check("post_rst_out", 32'(bus.out), 32'd6);
        check("post_rst_last", 32'(bus.out_last), 32'd1);
        step();
        check("post_rst_done", 32'(bus.out_valid), 32'd0);

`ifdef PRIORITY_ENCODER_SEQ_B2B_EN
        send_vec(8'h03);
        check("b2b_out0", 32'(bus.out), 32'd0);
        bus.in       = 8'h80;
        bus.in_valid = 1'b1;
        step();
        check("b2b_out1", 32'(bus.out), 32'd1);
        check("b2b_rdy", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        check("b2b_out7", 32'(bus.out), 32'd7);
        check("b2b_valid7", 32'(bus.out_valid), 32'd1);
        step();
`endif

        for (int c = 0; c < 600; c++) begin
            rst           = ($urandom_range(0, 99) < 2);
            bus.in_valid  = $urandom_range(0, 1);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       bus.in = 8'h00;
                1:       bus.in = 8'd1 << $urandom_range(0, 7);
                default: bus.in = 8'($urandom);
            endcase
            step();
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/priority_encoder_seq.md
# priority_encoder_seq

Sequential 8-to-3 encoder that converts an 8-bit request vector into a stream of 3-bit indices, one per handshake beat, lowest set bit first. It is the encode side of the 3-to-8 one-hot decode path. A decoded one-hot word fed in yields exactly one index, which round-trips the decoder. A multi-hot word is serialized into all of its indices in ascending order. The block sits between a request-vector producer and any index consumer using valid/ready flow control.

## Interface
- No parameters; widths fixed at 8 in / 3 out.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in  input  8  request vector; bit i set = index i requested.
- in_valid  input  1  producer has a vector on `in`.
- in_ready  output  1  block can accept a vector this cycle.
- out  output  3  index of the lowest still-pending set bit.
- out_valid  output  1  `out` holds a valid index.
- out_ready  input  1  consumer takes `out` this cycle.
- out_last  output  1  current beat is the final index of the vector.
- err_zero  output  1  one-cycle pulse: an all-zero vector was accepted.

## Operation
- Internal state: FSM {IDLE, EMIT}, `pending[7:0]` register.
- Accept = in_valid && in_ready, sampled at the clock edge.
- IDLE:
  - in_ready=1.
  - On accept with in≠0: pending<=in, go to EMIT.
  - On accept with in==0: stay in IDLE, emit nothing, and pulse err_zero high for the following cycle.
- EMIT:
  - out_valid=1.
  - out = index of the lowest set bit of pending (combinational from the register).
  - out_last = 1 when pending has exactly one bit set.
  - out and out_last hold stable while out_ready=0.
- Beat = out_valid && out_ready.
  - On a beat, clear that bit of pending.
  - If out_last=1, go to IDLE and set pending<=0.
- in_ready=0 throughout EMIT, except as allowed by the configuration macro below.
- `in` changes while in EMIT are ignored; pending is owned by the FSM.
- Reset, applied at any time including mid-vector:
  - state<=IDLE, pending<=0.
  - out_valid=0, out=3'd0, out_last=0, err_zero=0.
  - in_ready=0 while rst=1; in_ready=1 from the first cycle after rst deasserts.
  - A partially emitted vector is discarded, with no further beats.

## Timing
- Latency: a vector accepted at edge k gives out_valid=1 in the cycle after edge k.
- Throughput: one index per cycle while out_ready=1.
- A vector with N set bits takes N beats.
- Default (macro off): N beats plus one IDLE cycle per vector.
- out_valid never drops before its beat completes.
- err_zero is registered: a high pulse in the cycle after the accepting edge.

## Configuration
- Macro: `PRIORITY_ENCODER_SEQ_B2B_EN`.
- Defined:
  - in_ready = 1 also in EMIT when out_last && out_ready (back-to-back).
  - A simultaneous final beat and accept loads the new pending and stays in EMIT.
  - Sustained throughput is 1 index/cycle with no bubble between vectors.
  - A simultaneous final beat and accept of a zero vector goes to IDLE and pulses err_zero.
- Undefined:
  - in_ready=1 only in IDLE, giving a one-cycle bubble between vectors.

## Test plan
- Reset, then in=8'b0000_1000 with in_valid for one cycle and out_ready=1 -> next cycle out=3'd3, out_valid=1, out_last=1; the cycle after that out_valid=0 and in_ready=1.
- Round-trip all eight one-hot inputs 8'h01..8'h80 -> out=0..7 respectively, each with out_last=1.
- in=8'b1010_0101 with out_ready=1 -> beats out=0,2,5,7 on consecutive cycles; out_last only on 7; in_ready=0 for those 4 cycles.
- Same vector with out_ready low for 3 cycles after the first beat -> out holds 3'd2 with out_valid=1 throughout, then resumes 5, 7.
- Accept in=8'h00 -> err_zero=1 for exactly one cycle, out_valid stays 0, in_ready stays 1.
- Assert rst in the middle of 8'hFF after 3 beats -> the next cycle shows out_valid=0 and in_ready=0; after release, in=8'h40 produces a single beat out=6. With `PRIORITY_ENCODER_SEQ_B2B_EN`, vectors 8'h03 then 8'h80 stream as 0,1,7 on three consecutive cycles.
